muldiv_sequencer: RTL



---
 rtl/muldiv_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// HI/LO multi-cycle sequencer: iterative shift-add multiply, restoring divide,
// and single-cycle MTHI/MTLO writes into the HiLo register write port.
//
// state   | meaning
// S_IDLE  | waiting for Start; MTHI/MTLO complete here in one cycle
// S_CALC  | one multiply/divide iteration per cycle, WIDTH cycles
// S_FIX   | sign correction, load HiLoWrite, raise HiLoEn
// S_WRITE | HiLoEn pulse visible; drop Busy and return to idle
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [2:0]         Op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2*WIDTH-1:0] HiLoRead,
  output logic [2*WIDTH-1:0] HiLoWrite,
  output logic               HiLoEn,
  output logic               Busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIX   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_opa;    // multiplicand, or dividend shifting out MSB-first
  logic [WIDTH-1:0]   r_opb;    // multiplier shifting out LSB-first, or divisor
  logic [2*WIDTH-1:0] r_acc;    // product, or {remainder, quotient}
  logic               r_is_div;
  logic               r_neg_q;  // negate product (mult) or quotient (div)
  logic               r_neg_r;  // negate remainder
  logic               r_div0;
  logic [2*WIDTH-1:0] r_hilo_write;
  logic               r_hilo_en;
  logic               r_busy;

  logic               w_arith_start;
  logic               w_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_result;

  assign w_arith_start = Start && !Op[2];
  assign w_signed      = !Op[0];
  assign w_abs_a       = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_abs_b       = (w_signed && B[WIDTH-1]) ? -B : B;

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_opb[0] ? r_opa : '0)};

  // Divide: remainder is kept below the divisor, so the difference always fits
  // in WIDTH bits; a zero divisor simply accumulates the dividend unchanged.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_opa[WIDTH-1]};
  assign w_div_ge   = (w_rem_sh >= {1'b0, r_opb});
  assign w_div_diff = w_rem_sh[WIDTH-1:0] - r_opb;

  // Divide by zero reports an all-ones quotient regardless of signedness.
  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_quo    = r_div0 ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_result = r_is_div ? {w_rem, w_quo} : w_prod;

  assign HiLoWrite = r_hilo_write;
  assign HiLoEn    = r_hilo_en;
  assign Busy      = r_busy;

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_arith_start) w_next = S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(WIDTH-1)) w_next = S_FIX;
      S_FIX:   w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and registered outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt        <= '0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_acc        <= '0;
      r_is_div     <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_div0       <= 1'b0;
      r_hilo_write <= '0;
      r_hilo_en    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_hilo_en <= 1'b0;
          if (w_arith_start) begin
            r_opa    <= w_abs_a;
            r_opb    <= w_abs_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= Op[1];
            r_neg_q  <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_r  <= w_signed && A[WIDTH-1];
            r_div0   <= Op[1] && (B == '0);
            r_busy   <= 1'b1;
          end else if (Start && Op == 3'b100) begin
            r_hilo_write <= {A, HiLoRead[WIDTH-1:0]};
            r_hilo_en    <= 1'b1;
          end else if (Start && Op == 3'b101) begin
            r_hilo_write <= {HiLoRead[2*WIDTH-1:WIDTH], A};
            r_hilo_en    <= 1'b1;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_is_div) begin
            r_acc <= {(w_div_ge ? w_div_diff : w_rem_sh[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_div_ge};
            r_opa <= r_opa << 1;
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            r_opb <= r_opb >> 1;
          end
        end
        S_FIX: begin
          r_hilo_write <= w_result;
          r_hilo_en    <= 1'b1;
        end
        S_WRITE: begin
          r_hilo_en <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
